// File: rtl/multdiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO registers of the multicycle MIPS core.
// Optional macro MULTDIV_DIV0_FLAG_EN adds o_div0 and suppresses the HI/LO write on divide-by-zero.
module multdiv_sequencer #(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_stall,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
`ifdef MULTDIV_DIV0_FLAG_EN
    ,
    output logic         o_div0
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return {W{1'b0}} - v;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return {(2*W){1'b0}} - v;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_acc_hi;
    logic [W-1:0]    r_acc_lo;
    logic [W-1:0]    r_opnd;
    logic            r_is_div;
    logic            r_sa;
    logic            r_neg;
    logic            r_bz;
    logic            r_done;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
`ifdef MULTDIV_DIV0_FLAG_EN
    logic            r_div0;
`endif

    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_mul_sum;
    logic [W:0]      w_div_shift;
    logic [W-1:0]    w_div_sub;
    logic            w_div_ge;
    logic [W-1:0]    w_next_hi;
    logic [W-1:0]    w_next_lo;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_fix_hi;
    logic [W-1:0]    w_fix_lo;

    // Operand sign extraction and magnitudes; op[0]==0 selects the signed variants.
    always_comb begin
        w_a_neg = ~i_op[0] & i_a[W-1];
        w_b_neg = ~i_op[0] & i_b[W-1];
        w_a_mag = w_a_neg ? neg_w(i_a) : i_a;
        w_b_mag = w_b_neg ? neg_w(i_b) : i_b;
    end

    // One shift-add (multiply) or restoring (divide) step on the accumulator pair.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_div_shift = {r_acc_hi, r_acc_lo[W-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        // Modular W-bit subtract is exact whenever the trial succeeds.
        w_div_sub   = w_div_shift[W-1:0] - r_opnd;
        if (r_is_div) begin
            if (w_div_ge) begin
                w_next_hi = w_div_sub;
                w_next_lo = {r_acc_lo[W-2:0], 1'b1};
            end else begin
                w_next_hi = w_div_shift[W-1:0];
                w_next_lo = {r_acc_lo[W-2:0], 1'b0};
            end
        end else begin
            w_next_hi = w_mul_sum[W:1];
            w_next_lo = {w_mul_sum[0], r_acc_lo[W-1:1]};
        end
    end

    // Sign correction applied in FIX; divide-by-zero keeps an all-ones quotient and raw dividend.
    always_comb begin
        w_prod = {r_acc_hi, r_acc_lo};
        if (r_is_div) begin
            w_fix_hi = r_sa ? neg_w(r_acc_hi) : r_acc_hi;
            if (r_bz) begin
                w_fix_lo = {W{1'b1}};
            end else begin
                w_fix_lo = r_neg ? neg_w(r_acc_lo) : r_acc_lo;
            end
        end else begin
            if (r_neg) begin
                {w_fix_hi, w_fix_lo} = neg_2w(w_prod);
            end else begin
                {w_fix_hi, w_fix_lo} = w_prod;
            end
        end
    end

    // Sequencer FSM, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_acc_hi <= {W{1'b0}};
            r_acc_lo <= {W{1'b0}};
            r_opnd   <= {W{1'b0}};
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_neg    <= 1'b0;
            r_bz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= {W{1'b0}};
            r_lo     <= {W{1'b0}};
`ifdef MULTDIV_DIV0_FLAG_EN
            r_div0   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULTDIV_DIV0_FLAG_EN
            r_div0 <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_op[2]) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= {CW{1'b0}};
                        r_is_div <= i_op[1];
                        r_sa     <= w_a_neg;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_bz     <= (i_b == {W{1'b0}});
                        r_acc_hi <= {W{1'b0}};
                        r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
                        r_acc_lo <= i_op[1] ? w_a_mag : w_b_mag;
                    end else if (i_start && (i_op == 3'd4)) begin
                        r_hi <= i_a;
                    end else if (i_start && (i_op == 3'd5)) begin
                        r_lo <= i_a;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(W-1)) begin
                        r_state <= ST_FIX;
                        r_done  <= 1'b1;
`ifdef MULTDIV_DIV0_FLAG_EN
                        r_div0  <= r_is_div & r_bz;
`endif
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
`ifdef MULTDIV_DIV0_FLAG_EN
                    if (!(r_is_div && r_bz)) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
`else
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must react in the request cycle, so it decodes start directly.
    always_comb begin
        o_stall = ((r_state == ST_IDLE) && i_start && !i_op[2]) || (r_state == ST_RUN);
        o_busy  = (r_state != ST_IDLE);
        o_done  = r_done;
        o_hi    = r_hi;
        o_lo    = r_lo;
    end

`ifdef MULTDIV_DIV0_FLAG_EN
    assign o_div0 = r_div0;
`endif

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: fixed vectors, randomized ops against an arithmetic model.
module tb_multdiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        tb_div0;

    int n_pass   = 0;
    int n_checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    multdiv_sequencer #(.W(32), .CW(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_stall (o_stall),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
`ifdef MULTDIV_DIV0_FLAG_EN
        ,
        .o_div0  (tb_div0)
`endif
    );
`ifndef MULTDIV_DIV0_FLAG_EN
    assign tb_div0 = 1'b0;
`endif

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO state.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit e_div0);
        longint sa, sb;
        logic [63:0] p;
        e_div0 = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    e_div0 = 1'b1;
`ifndef MULTDIV_DIV0_FLAG_EN
                    m_lo = 32'hFFFFFFFF;
                    m_hi = a;
`endif
                end else if (op == 3'd2) begin
                    p = sa / sb; m_lo = p[31:0];
                    p = sa % sb; m_hi = p[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Drives a multicycle op like the decoder (start held while stalled), returns observations.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output int n_s, output int n_b, output bit got,
                          output logic [31:0] fh, output logic [31:0] fl, output logic fd);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        n_s = 0; n_b = 0; got = 1'b0; fh = 32'd0; fl = 32'd0; fd = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (o_stall) n_s++;
            if (o_busy) n_b++;
            if (o_done) begin
                got = 1'b1; fh = o_hi; fl = o_lo; fd = tb_div0;
                break;
            end
            @(negedge clk);
            if (noise && c == 0) begin
                i_op = 3'd4; i_a = $urandom; i_b = $urandom;
            end
        end
        i_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives a single-cycle op (MTHI/MTLO/NOP) and returns the stall seen in the request cycle.
    task automatic run_short(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic s);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        #1 s = o_stall;
        @(negedge clk);
        i_start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_op = 3'd0; i_a = 32'd0; i_b = 32'd0;
        #23;
        n_checks++;
        if ({o_hi, o_lo, o_stall, o_busy, o_done, tb_div0} !== 68'd0)
            $display("FAIL reset: hi=%h lo=%h stall=%b busy=%b done=%b div0=%b, required all 0",
                     o_hi, o_lo, o_stall, o_busy, o_done, tb_div0);
        else n_pass++;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_spec_vectors();
        logic [2:0]  vop [6];
        logic [31:0] va [6], vb [6], vh [6], vl [6];
        int n_s, n_b; bit got, ed; logic [31:0] fh, fl, ph, pl; logic fd;
        vop = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
        va  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h00001234};
        vb  = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
        vh  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h00001234};
        vl  = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
`ifdef MULTDIV_DIV0_FLAG_EN
        vh[5] = 32'd0; vl[5] = 32'h80000000;
`endif
        for (int i = 0; i < 6; i++) begin
            ph = m_hi; pl = m_lo;
            model_op(vop[i], va[i], vb[i], ed);
            run_op(vop[i], va[i], vb[i], 1'b0, n_s, n_b, got, fh, fl, fd);
            n_checks++;
            if (!got || n_s != 33 || n_b != 33)
                $display("FAIL vec%0d timing: done=%b stall_cycles=%0d busy_cycles=%0d, required 1/33/33",
                         i, got, n_s, n_b);
            else n_pass++;
            n_checks++;
            if ({fh, fl} !== {ph, pl})
                $display("FAIL vec%0d fix_read: hi=%h lo=%h, required old %h %h", i, fh, fl, ph, pl);
            else n_pass++;
            n_checks++;
            if ({o_hi, o_lo} !== {vh[i], vl[i]})
                $display("FAIL vec%0d result: hi=%h lo=%h, required %h %h", i, o_hi, o_lo, vh[i], vl[i]);
            else n_pass++;
`ifdef MULTDIV_DIV0_FLAG_EN
            n_checks++;
            if (fd !== (i == 5))
                $display("FAIL vec%0d div0: got %b, required %b", i, fd, (i == 5));
            else n_pass++;
`endif
        end
    endtask

    task automatic test_mt_back_to_back();
        logic s1, s2;
        @(negedge clk);
        i_start = 1'b1; i_op = 3'd4; i_a = 32'hA5A5A5A5; i_b = 32'd0;
        #1 s1 = o_stall;
        @(negedge clk);
        i_op = 3'd5; i_a = 32'h5A5A5A5A;
        #1 s2 = o_stall;
        n_checks++;
        if (o_hi !== 32'hA5A5A5A5 || o_lo !== m_lo)
            $display("FAIL mthi: hi=%h lo=%h, required %h %h", o_hi, o_lo, 32'hA5A5A5A5, m_lo);
        else n_pass++;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        n_checks++;
        if ({s1, s2, o_stall, o_busy} !== 4'b0000)
            $display("FAIL mt_stall: stall seq=%b%b%b busy=%b, required 0000", s1, s2, o_stall, o_busy);
        else n_pass++;
        n_checks++;
        if ({o_hi, o_lo} !== {32'hA5A5A5A5, 32'h5A5A5A5A})
            $display("FAIL mtlo: hi=%h lo=%h, required a5a5a5a5 5a5a5a5a", o_hi, o_lo);
        else n_pass++;
        m_hi = 32'hA5A5A5A5; m_lo = 32'h5A5A5A5A;
    endtask

    task automatic test_back_to_back();
        int n_s, n_b, n_done; bit got, ed; logic [31:0] fh, fl; logic fd;
        for (int k = 0; k < 2; k++) begin
            model_op(3'd1, 32'd12345 + k, 32'd678, ed);
            run_op(3'd1, 32'd12345 + k, 32'd678, 1'b1, n_s, n_b, got, fh, fl, fd);
            n_checks++;
            if (!got || n_s != 33 || {o_hi, o_lo} !== {m_hi, m_lo})
                $display("FAIL b2b%0d: done=%b stall=%0d hi=%h lo=%h, required 1/33 %h %h",
                         k, got, n_s, o_hi, o_lo, m_hi, m_lo);
            else n_pass++;
        end
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done || o_busy) n_done++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (n_done != 0)
            $display("FAIL idle_after: active cycles=%0d, required 0", n_done);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b, ph, pl, fh, fl; logic fd, s;
        int n_s, n_b, sel; bit got, ed;
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) a = 32'h80000000;
            if (sel == 2) b = 32'hFFFFFFFF;
            if (sel == 3) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
            ph = m_hi; pl = m_lo;
            model_op(op, a, b, ed);
            if (op <= 3'd3) begin
                run_op(op, a, b, (i % 3) == 0, n_s, n_b, got, fh, fl, fd);
                n_checks++;
                if (!got || n_s != 33 || n_b != 33)
                    $display("FAIL rnd%0d timing op=%0d: done=%b stall=%0d busy=%0d, required 1/33/33",
                             i, op, got, n_s, n_b);
                else n_pass++;
                n_checks++;
                if ({fh, fl} !== {ph, pl})
                    $display("FAIL rnd%0d fix_read: hi=%h lo=%h, required %h %h", i, fh, fl, ph, pl);
                else n_pass++;
`ifdef MULTDIV_DIV0_FLAG_EN
                n_checks++;
                if (fd !== ed)
                    $display("FAIL rnd%0d div0: got %b, required %b", i, fd, ed);
                else n_pass++;
`endif
            end else begin
                run_short(op, a, b, s);
                n_checks++;
                if (s !== 1'b0 || o_busy !== 1'b0)
                    $display("FAIL rnd%0d short op=%0d: stall=%b busy=%b, required 0 0", i, op, s, o_busy);
                else n_pass++;
            end
            n_checks++;
            if ({o_hi, o_lo} !== {m_hi, m_lo})
                $display("FAIL rnd%0d result op=%0d a=%h b=%h: hi=%h lo=%h, required %h %h",
                         i, op, a, b, o_hi, o_lo, m_hi, m_lo);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int n_s, n_b; bit got, ed; logic [31:0] fh, fl; logic fd, s;
        run_short(3'd4, 32'h11112222, 32'd0, s);
        run_short(3'd5, 32'h33334444, 32'd0, s);
        @(negedge clk);
        i_start = 1'b1; i_op = 3'd0; i_a = 32'hFFFFFFF0; i_b = 32'd99;
        for (int c = 0; c < 10; c++) @(negedge clk);
        #2;
        rst_n = 1'b0; i_start = 1'b0;
        #1;
        n_checks++;
        if ({o_hi, o_lo, o_stall, o_busy, o_done} !== 67'd0)
            $display("FAIL abort: hi=%h lo=%h stall=%b busy=%b done=%b, required all 0",
                     o_hi, o_lo, o_stall, o_busy, o_done);
        else n_pass++;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_op(3'd1, 32'd2, 32'd3, ed);
        run_op(3'd1, 32'd2, 32'd3, 1'b0, n_s, n_b, got, fh, fl, fd);
        n_checks++;
        if (!got || n_s != 33 || o_hi !== 32'd0 || o_lo !== 32'd6)
            $display("FAIL after_abort: done=%b stall=%0d hi=%h lo=%h, required 1/33 0 6",
                     got, n_s, o_hi, o_lo);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_mt_back_to_back();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
